// File: rtl/fb_pkg.sv
// Shared framebuffer constants, RGB565 field layout and fill-walker state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FB_W/FB_H/ADDR_W geometry, coordinate/counter widths, RGB565 field
// positions (shared with the VGA output path), walker_state_t, fb_addr().
package fb_pkg;

  localparam int FB_W    = 400;
  localparam int FB_H    = 300;
  localparam int ADDR_W  = 17;
  localparam int COORD_W = 9;
  // Walker coordinates can run past 511 (x0 + w - 1 up to 1021), so they carry one extra bit.
  localparam int CNT_W   = 10;
  localparam int COLOR_W = 16;

  // RGB565 field positions.
  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  typedef enum logic [1:0] {
    WK_IDLE   = 2'd0,
    WK_RUN    = 2'd1,
    WK_FINISH = 2'd2
  } walker_state_t;

  // Linear framebuffer address at full ADDR_W width; only meaningful for unclipped pixels.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [CNT_W-1:0] x,
                                                input logic [CNT_W-1:0] y);
    return ADDR_W'(x) + ADDR_W'(y) * ADDR_W'(FB_W);
  endfunction

endpackage

// File: rtl/fb_write_scheduler_if.sv
// Bundle of the pixel port, fill command port and video RAM write port.
// Latency: n/a (wiring only).
// Backpressure: pixReq held until pixAck; fillStart ignored while fillBusy.
//
// master: game logic / RAM side view. slave: fb_write_scheduler view.
interface fb_write_scheduler_if;
  import fb_pkg::*;

  logic                pixReq;
  logic [COORD_W-1:0]  pixX;
  logic [COORD_W-1:0]  pixY;
  logic [COLOR_W-1:0]  pixColor;
  logic                pixAck;

  logic                fillStart;
  logic [COORD_W-1:0]  fillX;
  logic [COORD_W-1:0]  fillY;
  logic [COORD_W-1:0]  fillW;
  logic [COORD_W-1:0]  fillH;
  logic [COLOR_W-1:0]  fillColor;
  logic                fillBusy;
  logic                fillDone;

  logic [ADDR_W-1:0]   wrAddress;
  logic [COLOR_W-1:0]  wrData;
  logic                wren;

  modport master (
    output pixReq, pixX, pixY, pixColor,
    output fillStart, fillX, fillY, fillW, fillH, fillColor,
    input  pixAck, fillBusy, fillDone,
    input  wrAddress, wrData, wren
  );

  modport slave (
    input  pixReq, pixX, pixY, pixColor,
    input  fillStart, fillX, fillY, fillW, fillH, fillColor,
    output pixAck, fillBusy, fillDone,
    output wrAddress, wrData, wren
  );

endinterface

// File: rtl/rect_fill_walker.sv
// Rectangle walker: offers one (cx,cy) pixel per cycle in raster order until w*h grants.
// Latency: first pixel offered the cycle after an accepted start; done pulses 2 cycles after the last grant.
// Backpressure: holds the current pixel until i_grant; i_start ignored unless IDLE.
//
// Ports: i_start + i_x/i_y/i_w/i_h/i_color (command), i_grant (pixel consumed),
//        o_vld/o_x/o_y/o_color/o_last (offered pixel), o_busy, o_done.
module rect_fill_walker
  import fb_pkg::*;
(
  input  logic               dataClock,
  input  logic               reset,
  input  logic               i_start,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_w,
  input  logic [COORD_W-1:0] i_h,
  input  logic [COLOR_W-1:0] i_color,
  input  logic               i_grant,
  output logic               o_vld,
  output logic               o_last,
  output logic [CNT_W-1:0]   o_x,
  output logic [CNT_W-1:0]   o_y,
  output logic [COLOR_W-1:0] o_color,
  output logic               o_busy,
  output logic               o_done
);

  walker_state_t      r_state;
  walker_state_t      w_state_next;
  logic [COORD_W-1:0] r_x0;
  logic [COORD_W-1:0] r_y0;
  logic [COORD_W-1:0] r_w;
  logic [COORD_W-1:0] r_h;
  logic [COLOR_W-1:0] r_color;
  logic [CNT_W-1:0]   r_cx;
  logic [CNT_W-1:0]   r_cy;
  logic               r_done;

  logic [CNT_W-1:0]   w_x_end;
  logic [CNT_W-1:0]   w_y_end;
  logic               w_row_end;
  logic               w_last;
  logic               w_accept;

  // Only meaningful in RUN, where w and h are both non-zero.
  assign w_x_end   = {1'b0, r_x0} + {1'b0, r_w} - CNT_W'(1);
  assign w_y_end   = {1'b0, r_y0} + {1'b0, r_h} - CNT_W'(1);
  assign w_row_end = (r_cx == w_x_end);
  assign w_last    = w_row_end && (r_cy == w_y_end);
  assign w_accept  = (r_state == WK_IDLE) && i_start;

  always_ff @(posedge dataClock) begin
    if (reset) begin
      r_state <= WK_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Registered so done lands one cycle after FINISH, the same cycle busy drops.
      r_done  <= (r_state == WK_FINISH);
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_vld        = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      WK_IDLE: begin
        if (i_start) begin
          w_state_next = ((i_w == '0) || (i_h == '0)) ? WK_FINISH : WK_RUN;
        end
      end
      WK_RUN: begin
        o_vld  = 1'b1;
        o_busy = 1'b1;
        if (i_grant && w_last) begin
          w_state_next = WK_FINISH;
        end
      end
      WK_FINISH: begin
        o_busy       = 1'b1;
        w_state_next = WK_IDLE;
      end
      default: begin
        w_state_next = WK_IDLE;
      end
    endcase
  end

  always_ff @(posedge dataClock) begin
    if (reset) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_color <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
    end else if (w_accept) begin
      r_x0    <= i_x;
      r_y0    <= i_y;
      r_w     <= i_w;
      r_h     <= i_h;
      r_color <= i_color;
      r_cx    <= {1'b0, i_x};
      r_cy    <= {1'b0, i_y};
    end else if ((r_state == WK_RUN) && i_grant) begin
      if (w_row_end) begin
        r_cx <= {1'b0, r_x0};
        r_cy <= r_cy + CNT_W'(1);
      end else begin
        r_cx <= r_cx + CNT_W'(1);
      end
    end
  end

  assign o_last  = o_vld && w_last;
  assign o_x     = r_cx;
  assign o_y     = r_cy;
  assign o_color = r_color;
  assign o_done  = r_done;

endmodule

// File: rtl/fb_write_scheduler.sv
// Shares the video RAM write port between the pixel port and the rectangle-fill walker.
// Latency: pixAck in the grant cycle; wren/wrAddress/wrData one cycle after the grant.
// Backpressure: pixReq waits for pixAck; walker stalls while the pixel port wins arbitration.
//
// Ports: dataClock, reset (sync, active-high); bus (slave): pixel port, fill command/status,
//        RAM write outputs. Clipped pixels (x >= FB_W or y >= FB_H) are granted but not written.
module fb_write_scheduler
  import fb_pkg::*;
(
  input  logic                 dataClock,
  input  logic                 reset,
  fb_write_scheduler_if.slave  bus
);

  logic               w_walk_vld;
  logic               w_walk_last;
  logic [CNT_W-1:0]   w_walk_x;
  logic [CNT_W-1:0]   w_walk_y;
  logic [COLOR_W-1:0] w_walk_color;
  logic               w_walk_busy;
  logic               w_walk_done;

  logic               w_pix_req;
  logic               w_fill_req;
  logic               w_gnt_pix;
  logic               w_gnt_fill;
  logic               w_gnt_any;
  logic [CNT_W-1:0]   w_sel_x;
  logic [CNT_W-1:0]   w_sel_y;
  logic [COLOR_W-1:0] w_sel_color;
  logic               w_clip;
  logic               w_write;

  // 0: pixel port wins the next contested cycle, 1: walker wins.
  logic               r_rr_fill;
  logic               r_wren;
  logic [ADDR_W-1:0]  r_addr;
  logic [COLOR_W-1:0] r_data;

  rect_fill_walker u_walker (
    .dataClock (dataClock),
    .reset     (reset),
    .i_start   (bus.fillStart),
    .i_x       (bus.fillX),
    .i_y       (bus.fillY),
    .i_w       (bus.fillW),
    .i_h       (bus.fillH),
    .i_color   (bus.fillColor),
    .i_grant   (w_gnt_fill),
    .o_vld     (w_walk_vld),
    .o_last    (w_walk_last),
    .o_x       (w_walk_x),
    .o_y       (w_walk_y),
    .o_color   (w_walk_color),
    .o_busy    (w_walk_busy),
    .o_done    (w_walk_done)
  );

  // No grants during reset so pixAck stays low and a mid-fill reset issues nothing further.
  assign w_pix_req  = bus.pixReq & ~reset;
  assign w_fill_req = w_walk_vld & ~reset;
  assign w_gnt_pix  = w_pix_req  & (~w_fill_req | ~r_rr_fill);
  assign w_gnt_fill = w_fill_req & (~w_pix_req  |  r_rr_fill);
  assign w_gnt_any  = w_gnt_pix | w_gnt_fill;

  assign w_sel_x     = w_gnt_pix ? {1'b0, bus.pixX} : w_walk_x;
  assign w_sel_y     = w_gnt_pix ? {1'b0, bus.pixY} : w_walk_y;
  assign w_sel_color = w_gnt_pix ? bus.pixColor     : w_walk_color;
  assign w_clip      = (w_sel_x >= CNT_W'(FB_W)) || (w_sel_y >= CNT_W'(FB_H));
  assign w_write     = w_gnt_any & ~w_clip;

  always_ff @(posedge dataClock) begin
    if (reset) begin
      r_rr_fill <= 1'b0;
      r_wren    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      // Pointer only moves on contested cycles, giving strict alternation under contention.
      if (w_pix_req && w_fill_req) begin
        r_rr_fill <= ~r_rr_fill;
      end
      r_wren <= w_write;
      if (w_write) begin
        r_addr <= fb_addr(w_sel_x, w_sel_y);
        r_data <= w_sel_color;
      end
    end
  end

  assign bus.pixAck    = w_gnt_pix;
  assign bus.fillBusy  = w_walk_busy;
  assign bus.fillDone  = w_walk_done;
  assign bus.wren      = r_wren;
  assign bus.wrAddress = r_addr;
  assign bus.wrData    = r_data;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: expected RAM writes are queued at stimulus
// time and checked by a monitor as wren pulses appear; each scenario task checks its own
// handshake/status timing.
module tb_fb_write_scheduler;
  import fb_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   wr_count;
  int   done_count;
  wr_t  exp_q[$];

  fb_write_scheduler_if bus();

  fb_write_scheduler dut (
    .dataClock (clk),
    .reset     (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (bus.wren === 1'b1) begin
      wr_count++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", bus.wrAddress, bus.wrData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.wrAddress !== e.addr || bus.wrData !== e.data) begin
          fails++;
          $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.wrAddress, bus.wrData, e.addr, e.data);
        end
      end
    end
    if (bus.fillDone === 1'b1) done_count++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int addr, input logic [15:0] data);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic start_fill(input int x, input int y, input int w, input int h, input logic [15:0] c);
    bus.fillStart = 1'b1;
    bus.fillX = 9'(x);
    bus.fillY = 9'(y);
    bus.fillW = 9'(w);
    bus.fillH = 9'(h);
    bus.fillColor = c;
  endtask

  // Returns cycles from the fillStart cycle to the fillDone cycle (caller is in cycle 1).
  task automatic wait_done(output int n);
    n = 1;
    while (bus.fillDone !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++;
    if (bus.wren !== 1'b0 || bus.wrAddress !== '0 || bus.wrData !== '0) begin
      fails++;
      $display("FAIL reset_write: got wren=%b addr=%0d data=%h, required 0/0/0", bus.wren, bus.wrAddress, bus.wrData);
    end
    tests++;
    if (bus.pixAck !== 1'b0 || bus.fillBusy !== 1'b0 || bus.fillDone !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: got ack=%b busy=%b done=%b, required 0/0/0", bus.pixAck, bus.fillBusy, bus.fillDone);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_pixel();
    bus.pixReq = 1'b1;
    bus.pixX = 9'd10;
    bus.pixY = 9'd2;
    bus.pixColor = 16'hF800;
    push(810, 16'hF800);
    #1;
    tests++;
    if (bus.pixAck !== 1'b1) begin
      fails++;
      $display("FAIL single_ack: got %b, required 1", bus.pixAck);
    end
    step();
    bus.pixReq = 1'b0;
    #1;
    tests++;
    if (bus.wren !== 1'b1 || bus.wrAddress !== 17'd810) begin
      fails++;
      $display("FAIL single_wren: got wren=%b addr=%0d, required 1/810", bus.wren, bus.wrAddress);
    end
    step();
    tests++;
    if (bus.wren !== 1'b0) begin
      fails++;
      $display("FAIL single_one_cycle: got wren=%b, required 0", bus.wren);
    end
  endtask

  task automatic test_fill_clip();
    int n;
    int wr0;
    int d0;
    wr0 = wr_count;
    d0 = done_count;
    push(119998, 16'h07E0);
    push(119999, 16'h07E0);
    start_fill(398, 299, 3, 2, 16'h07E0);
    step();
    bus.fillStart = 1'b0;
    tests++;
    if (bus.fillBusy !== 1'b1) begin
      fails++;
      $display("FAIL clip_busy: got %b, required 1", bus.fillBusy);
    end
    wait_done(n);
    tests++;
    if (n != 8) begin
      fails++;
      $display("FAIL clip_done_cycle: got %0d, required 8", n);
    end
    tests++;
    if (bus.fillBusy !== 1'b0) begin
      fails++;
      $display("FAIL clip_busy_drop: got %b, required 0", bus.fillBusy);
    end
    repeat (4) step();
    tests++;
    if (wr_count - wr0 != 2 || done_count - d0 != 1) begin
      fails++;
      $display("FAIL clip_counts: got writes=%0d dones=%0d, required 2/1", wr_count - wr0, done_count - d0);
    end
  endtask

  task automatic test_contention();
    int k;
    int n;
    logic exp_ack;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(2020 + i, 16'h1234 + 16'(i));
      push(i, 16'h001F);
    end
    start_fill(0, 0, 4, 1, 16'h001F);
    step();
    bus.fillStart = 1'b0;
    k = 0;
    bus.pixReq = 1'b1;
    bus.pixX = 9'd20;
    bus.pixY = 9'd5;
    bus.pixColor = 16'h1234;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_ack = (c % 2 == 0);
      tests++;
      if (bus.pixAck !== exp_ack) begin
        fails++;
        $display("FAIL contention_ack[%0d]: got %b, required %b", c, bus.pixAck, exp_ack);
      end
      if (bus.pixAck === 1'b1) k++;
      step();
      if (k < 4) begin
        bus.pixX = 9'(20 + k);
        bus.pixColor = 16'h1234 + 16'(k);
      end else begin
        bus.pixReq = 1'b0;
      end
    end
    wait_done(n);
    tests++;
    if (bus.fillDone !== 1'b1 || n != 2) begin
      fails++;
      $display("FAIL contention_done: got done=%b after %0d, required 1 after 2", bus.fillDone, n);
    end
    step();
  endtask

  task automatic test_zero_fill();
    int n;
    int wr0;
    int d0;
    wr0 = wr_count;
    d0 = done_count;
    start_fill(10, 10, 0, 5, 16'hAAAA);
    step();
    // Second start while busy must be ignored.
    start_fill(20, 20, 2, 2, 16'h5555);
    tests++;
    if (bus.fillBusy !== 1'b1) begin
      fails++;
      $display("FAIL zero_busy: got %b, required 1", bus.fillBusy);
    end
    step();
    bus.fillStart = 1'b0;
    tests++;
    if (bus.fillDone !== 1'b1) begin
      fails++;
      $display("FAIL zero_done_cycle2: got %b, required 1", bus.fillDone);
    end
    n = 0;
    repeat (10) step();
    tests++;
    if (wr_count != wr0 || done_count - d0 != 1 || bus.fillBusy !== 1'b0) begin
      fails++;
      $display("FAIL zero_counts: got writes=%0d dones=%0d busy=%b, required 0/1/0",
               wr_count - wr0, done_count - d0, bus.fillBusy);
    end
  endtask

  task automatic test_reset_mid_fill();
    int n;
    int d0;
    d0 = done_count;
    for (int i = 0; i < 37; i++) push((i % 10) + (i / 10) * 400, 16'hFFFF);
    start_fill(0, 0, 10, 10, 16'hFFFF);
    step();
    bus.fillStart = 1'b0;
    repeat (37) step();
    rst = 1'b1;
    step();
    tests++;
    if (bus.wren !== 1'b0 || bus.fillBusy !== 1'b0 || bus.fillDone !== 1'b0) begin
      fails++;
      $display("FAIL midreset_outputs: got wren=%b busy=%b done=%b, required 0/0/0",
               bus.wren, bus.fillBusy, bus.fillDone);
    end
    rst = 1'b0;
    repeat (20) step();
    tests++;
    if (done_count != d0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL midreset_aftermath: got dones=%0d pending=%0d, required 0/0", done_count - d0, exp_q.size());
    end
    push(2005, 16'h0F0F);
    start_fill(5, 5, 1, 1, 16'h0F0F);
    step();
    bus.fillStart = 1'b0;
    wait_done(n);
    tests++;
    if (n != 3) begin
      fails++;
      $display("FAIL midreset_restart: got done after %0d, required 3", n);
    end
    step();
  endtask

  task automatic test_out_of_range();
    int wr0;
    wr0 = wr_count;
    bus.pixReq = 1'b1;
    bus.pixX = 9'd400;
    bus.pixY = 9'd0;
    bus.pixColor = 16'hFFFF;
    #1;
    tests++;
    if (bus.pixAck !== 1'b1) begin
      fails++;
      $display("FAIL oor_x_ack: got %b, required 1", bus.pixAck);
    end
    step();
    bus.pixX = 9'd0;
    bus.pixY = 9'd300;
    #1;
    tests++;
    if (bus.pixAck !== 1'b1) begin
      fails++;
      $display("FAIL oor_y_ack: got %b, required 1", bus.pixAck);
    end
    step();
    bus.pixReq = 1'b0;
    repeat (3) step();
    tests++;
    if (wr_count != wr0) begin
      fails++;
      $display("FAIL oor_no_write: got %0d writes, required 0", wr_count - wr0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    wr_count = 0;
    done_count = 0;
    rst = 1'b1;
    bus.pixReq = 1'b0;
    bus.pixX = '0;
    bus.pixY = '0;
    bus.pixColor = '0;
    bus.fillStart = 1'b0;
    bus.fillX = '0;
    bus.fillY = '0;
    bus.fillW = '0;
    bus.fillH = '0;
    bus.fillColor = '0;
    test_reset();
    test_single_pixel();
    test_fill_clip();
    test_contention();
    test_zero_fill();
    test_reset_mid_fill();
    test_out_of_range();
    repeat (3) step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Owns the single video RAM write port (dataClock domain) and shares it between two requesters: a single-pixel write port used by game logic and an internal rectangle-fill engine used for clears and puck/paddle erase.
- Converts (x,y) into the linear framebuffer address x + y*400 and emits RGB565 write cycles.
- Sits between game logic and the video RAM write side; the VGA read side is untouched.

Parameters:
- FB_W, 400, framebuffer width in pixels
- FB_H, 300, framebuffer height in pixels
- ADDR_W, 17, write address width

Ports:
- dataClock  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pixReq  in  1  pixel write request, held until pixAck
- pixX  in  9  pixel column
- pixY  in  9  pixel row
- pixColor  in  16  RGB565 colour
- pixAck  out  1  one-cycle pulse: request consumed (written or clipped)
- fillStart  in  1  one-cycle pulse: latch rectangle and begin fill
- fillX  in  9  rectangle left column
- fillY  in  9  rectangle top row
- fillW  in  9  rectangle width
- fillH  in  9  rectangle height
- fillColor  in  16  fill colour
- fillBusy  out  1  high from the cycle after an accepted fillStart until done
- fillDone  out  1  one-cycle pulse when the fill completes
- wrAddress  out  17  video RAM write address
- wrData  out  16  video RAM write data
- wren  out  1  video RAM write enable

Behaviour:
- Reset (synchronous, active-high): wren=0, wrAddress=0, wrData=0, pixAck=0, fillBusy=0, fillDone=0, walker IDLE, round-robin pointer points to the pixel port. Reset mid-fill aborts the fill with no fillDone pulse.
- Fill walker FSM:
  - IDLE -> RUN on fillStart when not busy. Latch x0, y0, w, h and colour; set cx=x0, cy=y0.
  - fillStart while busy is ignored.
  - w=0 or h=0: IDLE -> FINISH directly, so fillDone pulses 2 cycles after fillStart and no writes are issued.
  - RUN: offers one pixel (cx,cy) per cycle. On grant, cx increments; when cx = x0+w-1, cx wraps to x0 and cy increments. Granting the last pixel (cy = y0+h-1, cx = x0+w-1) -> FINISH.
  - FINISH: fillDone=1 for one cycle, fillBusy drops on the same cycle -> IDLE.
- Arbitration per cycle between pixel port (pixReq) and walker (RUN state):
  - Exactly one requester: it is granted.
  - Both requesting: alternate. The pointer flips after each contested grant, giving 50/50 interleave.
- Clipping: a pixel with x >= FB_W or y >= FB_H is granted normally but produces wren=0.
  - A clipped pixel-port request still pulses pixAck.
  - A clipped walker pixel still advances the walker.
  - A rectangle extending off-screen therefore finishes in w*h granted cycles.
- Address arithmetic: addr = x + y*FB_W, computed at full ADDR_W width. Max in-range value is 119999.
- Write stage is registered, with 1-cycle latency from grant to the wren/wrAddress/wrData outputs. pixAck pulses in the grant cycle.
- wren is high for exactly one cycle per unclipped grant.
- pixReq held high after pixAck is treated as a new request in the next arbitration cycle. Requesters must change or drop pixX, pixY and pixColor the cycle after ack.
- fillX..fillColor are sampled only on an accepted fillStart; later changes do not affect a running fill.

Decomposition:
- Shared package fb_pkg holds:
  - FB_W, FB_H, ADDR_W
  - RGB565 field positions (R 15:11, G 10:5, B 4:0), also used by the VGA output path
  - walker state encoding (IDLE, RUN, FINISH)
- One sub-module, rect_fill_walker: the FSM plus cx/cy counters, with a grant input and pixel/valid/last outputs.
- Arbitration, clipping, address computation and the output register stay in fb_write_scheduler.

Test Plan:
- Single pixel: pixReq with (10,2,0xF800), no fill -> pixAck in the grant cycle; next cycle wren=1, wrAddress=810, wrData=0xF800, for exactly one cycle.
- Fill 3x2 at (398,299), colour 0x07E0 -> six grants.
  - Writes only to addresses 120000-? none: (398,299)=119998 and (399,299)=119999 written.
  - Column 400 and row 300 are clipped, so exactly 2 wren pulses in total.
  - fillDone pulses once after the 6th grant.
- Contention: 4x1 fill at (0,0) while pixReq is held with a new pixel each ack -> grants alternate, pixel port first after reset. The wrAddress sequence interleaves pixel and walker addresses; fill completes in 8 cycles.
- Zero-size fill (w=0, h=5) -> no wren; fillDone 2 cycles after fillStart. A second fillStart during busy is ignored, so only one fillDone occurs.
- Reset asserted mid-fill of a 10x10 rectangle (after 37 grants) -> next cycle wren=0 and fillBusy=0, no fillDone, walker IDLE. A new fillStart is accepted afterwards.
- Out-of-range pixel (400,0) -> pixAck pulses, wren stays 0.
